// File: rtl/fpu_pkg.sv
// fpu_pkg: class/FCLASS bit indices, FSM state and operand format types
package fpu_pkg;

   localparam int CLS_ZERO = 0;
   localparam int CLS_SUB  = 1;
   localparam int CLS_NORM = 2;
   localparam int CLS_INF  = 3;
   localparam int CLS_SNAN = 4;
   localparam int CLS_QNAN = 5;

   localparam int FC_NINF  = 0;
   localparam int FC_NNORM = 1;
   localparam int FC_NSUB  = 2;
   localparam int FC_NZERO = 3;
   localparam int FC_PZERO = 4;
   localparam int FC_PSUB  = 5;
   localparam int FC_PNORM = 6;
   localparam int FC_PINF  = 7;
   localparam int FC_SNAN  = 8;
   localparam int FC_QNAN  = 9;

   typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
   typedef enum logic {FMT_S, FMT_D} fmt_t;

   // Expand the one-hot class plus sign into the ten-bit FCLASS mask
   function automatic logic [9:0] fclass(input logic s, input logic [5:0] c);
      logic [9:0] m;
      m = '0;
      m[FC_QNAN] = c[CLS_QNAN];
      m[FC_SNAN] = c[CLS_SNAN];
      m[s ? FC_NINF : FC_PINF] = c[CLS_INF];
      m[s ? FC_NNORM : FC_PNORM] = c[CLS_NORM];
      m[s ? FC_NSUB : FC_PSUB] = c[CLS_SUB];
      m[s ? FC_NZERO : FC_PZERO] = c[CLS_ZERO];
      return m;
   endfunction

endpackage

// File: rtl/fpu_lzc.sv
// fpu_lzc: leading-zero count over a W-bit window, saturating at W
module fpu_lzc #(
   parameter int W = 4,
   localparam int CW = $clog2(W + 1)
)(
   input  logic [W-1:0]  a,
   output logic [CW-1:0] cnt
);

   // Scan upward so the most significant set bit decides the count
   always_comb begin
      cnt = CW'(W);
      for (int i = 0; i < W; i++)
         if (a[i]) cnt = CW'(W - 1 - i);
   end

endmodule

// File: rtl/fpu_unpack_seq.sv
// fpu_unpack_seq: classifies a float register and unpacks it, normalising subnormals over several cycles
module fpu_unpack_seq
   import fpu_pkg::*;
#(
   parameter int FLEN = 32,
   parameter int NRM_STEP = 4,
   localparam int EXP_LEN = (FLEN == 64) ? 11 : 8,
   localparam int SIG_LEN = (FLEN == 64) ? 52 : 23,
   localparam int BIAS = 2 ** (EXP_LEN - 1) - 1,
   localparam int EW = EXP_LEN + 2,
   localparam int SW = SIG_LEN + 1,
   localparam int CW = $clog2(NRM_STEP + 1)
)(
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 flush_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [FLEN-1:0]      reg_i,
   input  logic                 fmt_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic                 sign_o,
   output logic signed [EW-1:0] exp_o,
   output logic [SIG_LEN:0]     sig_o,
   output logic [5:0]           class_o,
   output logic [9:0]           fullclass_o
);

   state_t          state;
   logic [63:0]     r64;
   logic [31:0]     r32;
   logic            dbl, box_bad, sgn, e_zero, e_max, f_zero, accept;
   logic [10:0]     e;
   logic [SIG_LEN-1:0] f;
   logic [EW-1:0]   bias, d_exp;
   logic [SW-1:0]   d_sig, sig_sh;
   logic [5:0]      d_cls;
   logic [CW-1:0]   lz;

   assign in_ready_o = resetn && (state == IDLE || (state == DONE && out_ready_i));
   assign accept = in_valid_i && in_ready_o;

   // Field extraction and classification of the offered operand; singles sit MSB-aligned in the wide significand
   always_comb begin
      r64 = 64'(reg_i);
      dbl = (FLEN == 64) && (fmt_t'(fmt_i) == FMT_D);
      box_bad = (FLEN == 64) && !dbl && (r64[63:32] != '1);
      r32 = box_bad ? 32'h7FC0_0000 : r64[31:0];
      sgn = dbl ? r64[63] : r32[31];
      e = dbl ? r64[62:52] : {3'b000, r32[30:23]};
      f = dbl ? SIG_LEN'(r64[51:0]) : SIG_LEN'(r32[22:0]) << (SIG_LEN - 23);
      e_zero = e == '0;
      e_max = dbl ? (e == '1) : (e[7:0] == '1);
      f_zero = f == '0;
      bias = dbl ? EW'(BIAS) : EW'(127);
      d_cls = '0;
      d_cls[CLS_QNAN] = e_max && !f_zero && f[SIG_LEN-1];
      d_cls[CLS_SNAN] = e_max && !f_zero && !f[SIG_LEN-1];
      d_cls[CLS_INF] = e_max && f_zero;
      d_cls[CLS_NORM] = !e_max && !e_zero;
      d_cls[CLS_SUB] = e_zero && !f_zero;
      d_cls[CLS_ZERO] = e_zero && f_zero;
      d_sig = {!e_zero, f};
      d_exp = e_max ? bias + EW'(1) : e_zero ? (f_zero ? '0 : EW'(1) - bias) : EW'(e) - bias;
   end

   fpu_lzc #(.W(NRM_STEP)) u_lzc (
      .a   (sig_o[SIG_LEN -: NRM_STEP]),
      .cnt (lz)
   );

   assign sig_sh = sig_o << lz;

   // Control FSM; the output registers double as the normalisation working registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         out_valid_o <= 1'b0;
         sign_o <= 1'b0;
         exp_o <= '0;
         sig_o <= '0;
         class_o <= '0;
         fullclass_o <= '0;
      end else if (flush_i) begin
         state <= IDLE;
         out_valid_o <= 1'b0;
      end else if (accept) begin
         sign_o <= sgn;
         exp_o <= d_exp;
         sig_o <= d_sig;
         class_o <= d_cls;
         fullclass_o <= fclass(sgn, d_cls);
         state <= d_cls[CLS_SUB] ? NORM : DONE;
         out_valid_o <= !d_cls[CLS_SUB];
      end else if (state == NORM) begin
         sig_o <= sig_sh;
         exp_o <= exp_o - EW'(lz);
         state <= sig_sh[SIG_LEN] ? DONE : NORM;
         out_valid_o <= sig_sh[SIG_LEN];
      end else if (state == DONE && out_ready_i) begin
         state <= IDLE;
         out_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fpu_unpack_seq.sv
// tb_fpu_unpack_seq: scoreboard bench for the single-precision build plus directed checks on the FLEN=64 build
module tb_fpu_unpack_seq;

   typedef struct {
      logic       sign;
      int         e;
      logic [23:0] sig;
      logic [5:0] cls;
      logic [9:0] fc;
      int         due;
   } exp_t;

   logic        clk = 0, resetn = 0, flush = 0, in_valid = 0, fmt = 0, out_ready = 1;
   logic [31:0] rin = 0;
   logic        in_ready, out_valid, sign;
   logic [9:0]  exp_v, fcls;
   logic [23:0] sig;
   logic [5:0]  cls;

   logic        in_valid64 = 0, fmt64 = 0, flush64 = 0, out_ready64 = 1;
   logic [63:0] r64 = 0;
   logic        in_ready64, out_valid64, sign64;
   logic [12:0] exp64;
   logic [52:0] sig64;
   logic [5:0]  cls64;
   logic [9:0]  fcls64;

   int   cyc = 0, nchk = 0, nerr = 0, last_acc = 0;
   exp_t q[$];
   exp_t cur;
   logic fresh = 1;
   logic [31:0] vecs [14] = '{32'h3F800000, 32'h00000001, 32'hFF800000, 32'h7F800001, 32'h7FC00000,
                              32'h80000000, 32'h00000000, 32'hBF800000, 32'h80400000, 32'h00000010,
                              32'h7F7FFFFF, 32'h00800000, 32'h007FFFFF, 32'hFFC00001};
   logic [31:0] b2b [4] = '{32'h3F800000, 32'hC0000000, 32'h41200000, 32'h3E800000};

   fpu_unpack_seq #(.FLEN(32), .NRM_STEP(4)) u32 (
      .clk(clk), .resetn(resetn), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .reg_i(rin), .fmt_i(fmt), .out_valid_o(out_valid), .out_ready_i(out_ready), .sign_o(sign),
      .exp_o(exp_v), .sig_o(sig), .class_o(cls), .fullclass_o(fcls)
   );

   fpu_unpack_seq #(.FLEN(64), .NRM_STEP(4)) u64 (
      .clk(clk), .resetn(resetn), .flush_i(flush64), .in_valid_i(in_valid64), .in_ready_o(in_ready64),
      .reg_i(r64), .fmt_i(fmt64), .out_valid_o(out_valid64), .out_ready_i(out_ready64), .sign_o(sign64),
      .exp_o(exp64), .sig_o(sig64), .class_o(cls64), .fullclass_o(fcls64)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      nchk++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // Reference unpack of a single-precision value accepted in cycle n
   function automatic exp_t model(input logic [31:0] v, input int n);
      exp_t x;
      logic [7:0] ef;
      logic [22:0] fr;
      int sh;
      ef = v[30:23];
      fr = v[22:0];
      x.sign = v[31];
      x.due = n + 1;
      sh = 0;
      if (ef == 8'hFF) begin
         x.e = 128;
         x.sig = {1'b1, fr};
         x.cls = (fr == 0) ? 6'h08 : fr[22] ? 6'h20 : 6'h10;
      end else if (ef == 0 && fr == 0) begin
         x.e = 0;
         x.sig = 0;
         x.cls = 6'h01;
      end else if (ef == 0) begin
         for (int b = 0; b < 23; b++) if (fr[b]) sh = 23 - b;
         x.sig = 24'(fr) << sh;
         x.e = -126 - sh;
         x.cls = 6'h02;
         x.due = n + 1 + (sh + 3) / 4;
      end else begin
         x.e = int'(ef) - 127;
         x.sig = {1'b1, fr};
         x.cls = 6'h04;
      end
      case (x.cls)
         6'h20: x.fc = 10'h200;
         6'h10: x.fc = 10'h100;
         6'h08: x.fc = x.sign ? 10'h001 : 10'h080;
         6'h04: x.fc = x.sign ? 10'h002 : 10'h040;
         6'h02: x.fc = x.sign ? 10'h004 : 10'h020;
         6'h01: x.fc = x.sign ? 10'h008 : 10'h010;
         default: x.fc = 10'h000;
      endcase
      return x;
   endfunction

   // Offer v from a falling edge until accepted; returns on the falling edge after the accept
   task automatic send(input logic [31:0] v);
      int k = 0;
      in_valid = 1;
      rin = v;
      while (k < 100) begin
         #1;
         if (in_ready) begin
            q.push_back(model(v, cyc));
            last_acc = cyc;
            @(negedge clk);
            return;
         end
         @(negedge clk);
         k++;
      end
      check("accept_timeout", 0, 1);
   endtask

   task automatic drain();
      int k = 0;
      in_valid = 0;
      while (q.size() > 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("drain", q.size(), 0);
      @(negedge clk);
   endtask

   task automatic run64(input logic [63:0] v, input logic f, input logic s, input int e,
                        input logic [52:0] sg, input logic [5:0] c, input logic [9:0] fc, input int lat);
      int n;
      int k = 0;
      in_valid64 = 1;
      r64 = v;
      fmt64 = f;
      n = cyc;
      #1 check("rdy64", in_ready64, 1);
      @(negedge clk);
      in_valid64 = 0;
      while (!out_valid64 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("lat64", cyc - n, lat);
      check("sign64", sign64, s);
      check("exp64", 64'($signed(exp64)), 64'(e));
      check("sig64", sig64, sg);
      check("cls64", cls64, c);
      check("fcls64", fcls64, fc);
      @(negedge clk);
   endtask

   // Output monitor: pops one expectation per new result and re-checks it every cycle it is held
   always begin
      @(negedge clk);
      #2;
      if (resetn && out_valid) begin
         if (fresh) begin
            if (q.size() == 0) check("spurious_valid", 1, 0);
            else begin
               cur = q.pop_front();
               check("latency", cyc, cur.due);
            end
            fresh = 0;
         end
         check("sign", sign, cur.sign);
         check("exp", 64'($signed(exp_v)), 64'(cur.e));
         check("sig", sig, cur.sig);
         check("cls", cls, cur.cls);
         check("fcls", fcls, cur.fc);
         if (out_ready) fresh = 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int prev;
      repeat (2) @(negedge clk);
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_ready", in_ready, 0);
      check("rst_sign", sign, 0);
      check("rst_exp", exp_v, 0);
      check("rst_sig", sig, 0);
      check("rst_cls", cls, 0);
      check("rst_fcls", fcls, 0);
      check("rst_valid64", out_valid64, 0);
      @(negedge clk);
      resetn = 1;
      #1 check("rel_ready", in_ready, 1);
      @(negedge clk);
      foreach (vecs[i]) send(vecs[i]);
      repeat (6) send($urandom);
      drain();
      out_ready = 0;
      send(32'h40490FDB);
      in_valid = 0;
      #1 check("stall_ready", in_ready, 0);
      repeat (5) @(negedge clk);
      out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         prev = last_acc;
         send(b2b[i]);
         if (i > 0) check("b2b_accept", 64'(last_acc - prev), 1);
      end
      drain();
      send(32'h00000001);
      in_valid = 0;
      @(negedge clk);
      flush = 1;
      @(negedge clk);
      flush = 0;
      #1;
      check("flush_valid", out_valid, 0);
      check("flush_ready", in_ready, 1);
      q.delete();
      fresh = 1;
      repeat (8) @(negedge clk);
      #1 check("flush_quiet", out_valid, 0);
      @(negedge clk);
      flush = 1;
      in_valid = 1;
      rin = 32'h3F800000;
      @(negedge clk);
      flush = 0;
      in_valid = 0;
      #1;
      check("flush_pri_valid", out_valid, 0);
      check("flush_pri_ready", in_ready, 1);
      @(negedge clk);
      send(32'h00000001);
      in_valid = 0;
      @(negedge clk);
      #1 resetn = 0;
      #1;
      check("rstn_valid", out_valid, 0);
      check("rstn_sig", sig, 0);
      check("rstn_exp", exp_v, 0);
      check("rstn_cls", cls, 0);
      check("rstn_ready", in_ready, 0);
      q.delete();
      fresh = 1;
      @(negedge clk);
      resetn = 1;
      #1 check("rstn_rel_ready", in_ready, 1);
      @(negedge clk);
      send(32'h3F800000);
      drain();
      run64(64'h000000003F800000, 0, 0, 128, {24'hC00000, 29'b0}, 6'h20, 10'h200, 1);
      run64(64'hFFFFFFFF3F800000, 0, 0, 0, {24'h800000, 29'b0}, 6'h04, 10'h040, 1);
      run64(64'h3FF0000000000000, 1, 0, 0, {1'b1, 52'b0}, 6'h04, 10'h040, 1);
      run64(64'h0000000000000001, 1, 0, -1074, {1'b1, 52'b0}, 6'h02, 10'h020, 14);
      run64(64'hFFFFFFFF00000001, 0, 0, -149, {1'b1, 52'b0}, 6'h02, 10'h020, 7);
      run64(64'hFFF0000000000000, 1, 1, 1024, {1'b1, 52'b0}, 6'h08, 10'h001, 1);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/fpu_unpack_seq.md
FPU_UNPACK_SEQ -- requirements
Module: fpu_unpack_seq

Interface
REQ-001 Parameter FLEN, default 32, operand register width; legal values are 32 and 64.
REQ-002 Parameter NRM_STEP, default 4, maximum number of bits shifted per normalisation cycle; legal range is 1..8.
REQ-003 Derived constants: EXP_LEN is 8 or 11, SIG_LEN is 23 or 52, BIAS = 2^(EXP_LEN-1)-1; all follow FLEN.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 resetn  in  1  reset, asynchronous, active-low.
REQ-006 flush_i  in  1  synchronous abort of any operation in flight.
REQ-007 in_valid_i  in  1  operand offered.
REQ-008 in_ready_o  out  1  operand is accepted when in_valid_i and in_ready_o are both high.
REQ-009 reg_i  in  FLEN  raw floating-point register value.
REQ-010 fmt_i  in  1  operand format: 0 = single, 1 = double; ignored (treated as 0) when FLEN=32.
REQ-011 out_valid_o  out  1  result available.
REQ-012 out_ready_i  in  1  consumer accepts the result.
REQ-013 sign_o  out  1  sign of the operand.
REQ-014 exp_o  out  EXP_LEN+2  signed, unbiased exponent.
REQ-015 sig_o  out  SIG_LEN+1  significand with hidden bit, MSB-aligned.
REQ-016 class_o  out  6  one-hot class: qNaN(5), sNaN(4), inf(3), normal(2), subnormal(1), zero(0).
REQ-017 fullclass_o  out  10  RISC-V FCLASS mask: bit 9 = qNaN down to bit 0 = -inf.

Function
REQ-018 States are IDLE, NORM and DONE; in_ready_o is high in IDLE, and in DONE when out_ready_i is high.
REQ-019 On accept, the operand, its format and its class are registered; zero, normal, inf and NaN operands go to DONE, subnormal operands go to NORM.
REQ-020 Normal operand: exp_o = E - BIAS and sig_o = {1, fraction}.
REQ-021 Zero: exp_o = 0, sig_o = 0.
REQ-022 Inf and NaN: exp_o = BIAS+1, sig_o = {1, fraction}.
REQ-023 NORM shifts the significand left by min(NRM_STEP, leading zeros) each cycle until bit SIG_LEN is 1, while accumulating the shift count s; it moves to DONE in the cycle the leading 1 reaches bit SIG_LEN.
REQ-024 Subnormal result: exp_o = 1 - BIAS - s, where s is in 1..SIG_LEN.
REQ-025 Latency from the accept cycle N: out_valid_o rises at N+1 for non-subnormal operands and at N+1+ceil(s/NRM_STEP) for subnormal operands.
REQ-026 While out_valid_o is high and out_ready_i is low, all outputs hold stable.
REQ-027 DONE with out_ready_i high and in_valid_i high accepts the next operand in the same cycle, giving back-to-back throughput of one result per cycle for non-subnormal operands.
REQ-028 Single format with FLEN=64: if reg_i[63:32] is not all ones, the operand is replaced by canonical qNaN 0x7FC00000 (NaN-boxing).
REQ-029 Single format with FLEN=64: exp_o is sign-extended and sig_o is 24 bits left-aligned with the lower bits zero.
REQ-030 flush_i forces IDLE on the next edge and deasserts out_valid_o; flush_i has priority over an accept in the same cycle.
REQ-031 All NaNs report sNaN or qNaN by the fraction MSB; a NaN never reports inf.

Reset
REQ-032 resetn low immediately sets state to IDLE, out_valid_o to 0, and sign_o, exp_o, sig_o, class_o and fullclass_o to 0, including mid-NORM; in_ready_o rises once resetn is high.

Structure
REQ-033 Package fpu_pkg holds the class bit index constants, the FCLASS bit indices, the state enum and the format enum.
REQ-034 Sub-module fpu_lzc is a parametrised leading-zero counter over NRM_STEP bits, used by NORM.
REQ-035 The block contains no multi-cycle combinational paths; each NORM step uses one barrel stage of at most NRM_STEP bits.

Verification
REQ-036 FLEN=32, 0x3F800000 -> exp_o 0, sig_o 0x800000, class_o 0x04, fullclass_o 0x040, out_valid_o at N+1.
REQ-037 FLEN=32, NRM_STEP=4, 0x00000001 -> exp_o -149, sig_o 0x800000, class_o 0x02, fullclass_o 0x020, out_valid_o at N+7.
REQ-038 0xFF800000 -> class_o 0x08, fullclass_o 0x001; 0x7F800001 -> class_o 0x10, fullclass_o 0x100.
REQ-039 FLEN=64, fmt_i=0, reg_i 0x000000003F800000 -> qNaN result, class_o 0x20, fullclass_o 0x200.
REQ-040 out_ready_i held low for 5 cycles -> outputs stable across all 5 cycles; then a back-to-back stream of 4 normal operands -> 4 results in 4 consecutive cycles.
REQ-041 resetn pulsed low during NORM of 0x00000001 -> out_valid_o is 0 immediately, and a new operand is accepted after release.
